// File: rtl/core_pkg.sv
// Shared constants and the drain FSM state type used by the psum drain path.
package core_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } drain_state_t;

endpackage

// File: rtl/psum_drain_if.sv
// Bundle of psum drain signals: word input side, lane output side, buffer status.
interface psum_drain_if
    import core_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = 4
);

    // Input accepts in_data on any cycle in_valid=1 (no ready; drops set overflow).
    // Output lane transfers on a rising clk edge when out_valid=1 and out_ready=1;
    // while out_valid=1 and out_ready=0, out_data/out_col/out_last hold stable.
    logic [col*psum_bw-1:0]     in_data;
    logic                       in_valid;
    logic                       relu_en;
    logic [psum_bw-1:0]         out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [$clog2(col)-1:0]     out_col;
    logic                       out_last;
    logic                       full;
    logic                       empty;
    logic                       overflow;
    logic [$clog2(depth):0]     count;
    drain_state_t               dbg_state;

    modport slave (
        input  in_data, in_valid, relu_en, out_ready,
        output out_data, out_valid, out_col, out_last,
               full, empty, overflow, count, dbg_state
    );

    modport master (
        output in_data, in_valid, relu_en, out_ready,
        input  out_data, out_valid, out_col, out_last,
               full, empty, overflow, count, dbg_state
    );

endinterface

// File: rtl/psum_fifo.sv
// Circular word buffer with registered full/empty; push while full succeeds only with a pop.
module psum_fifo #(
    parameter int width = 128,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [width-1:0]         i_data,
    output logic [width-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(depth):0]   o_count
);

    localparam int AW = $clog2(depth);
    localparam int NW = AW + 1;

    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [NW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [NW-1:0]    w_count_next;

    assign w_do_pop  = i_pop && !r_empty;
    assign w_do_push = i_push && (!r_full || w_do_pop);

    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_do_push)
                r_wptr <= (r_wptr == AW'(depth - 1)) ? '0 : r_wptr + 1'b1;
            if (w_do_pop)
                r_rptr <= (r_rptr == AW'(depth - 1)) ? '0 : r_rptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == NW'(depth));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/psum_drain.sv
// Drains SFP output words one psum lane at a time through a word buffer,
// a serializer FSM and a per-lane ReLU mux.
module psum_drain
    import core_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = 4
) (
    input  logic         clk,
    input  logic         reset,
    psum_drain_if.slave  bus
);

    localparam int CW = $clog2(col);
    localparam int WW = col * psum_bw;

    drain_state_t          r_state;
    drain_state_t          w_next_state;
    logic [WW-1:0]         r_sreg;
    logic [CW-1:0]         r_col;
    logic                  r_overflow;

    logic                  w_out_valid;
    logic                  w_last;
    logic                  w_xfer;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_load;
    logic                  w_push;
    logic                  w_drop;
    logic [WW-1:0]         w_fifo_data;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(depth):0] w_count;
    logic [psum_bw-1:0]    w_lane;

    psum_fifo #(
        .width (WW),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.in_data),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_empty || bus.in_valid) w_next_state = SHIFT;
            SHIFT:   if (w_xfer && w_last && w_empty) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // An idle drain with an empty buffer loads the incoming word directly,
    // so lane 0 appears the cycle after the push.
    always_comb begin
        w_out_valid = (r_state == SHIFT);
        w_last      = w_out_valid && (r_col == CW'(col - 1));
        w_xfer      = w_out_valid && bus.out_ready;
        w_pop       = 1'b0;
        w_bypass    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty)
                    w_pop = 1'b1;
                else if (bus.in_valid)
                    w_bypass = 1'b1;
            end
            SHIFT:   w_pop = w_xfer && w_last && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    assign w_load = w_pop || w_bypass;
    assign w_push = bus.in_valid && !w_bypass;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sreg <= '0;
            r_col  <= '0;
        end else if (w_load) begin
            r_sreg <= w_bypass ? bus.in_data : w_fifo_data;
            r_col  <= '0;
        end else if (w_xfer) begin
            r_sreg <= r_sreg >> psum_bw;
            r_col  <= w_last ? '0 : r_col + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
    end

    // The current lane always sits in the low bits of the shift register.
    assign w_lane = r_sreg[psum_bw-1:0];

    assign bus.out_data  = !w_out_valid ? '0 :
                           (bus.relu_en && w_lane[psum_bw-1]) ? '0 : w_lane;
    assign bus.out_valid = w_out_valid;
    assign bus.out_col   = r_col;
    assign bus.out_last  = w_last;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.overflow  = r_overflow;
    assign bus.count     = w_count;
    assign bus.dbg_state = r_state;

endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 SHALL have parameter col, default 8, meaning the number of psum lanes per input word.
REQ-002 SHALL have parameter psum_bw, default 16, meaning the width of one lane in bits.
REQ-003 SHALL have parameter depth, default 4, meaning the buffer depth in words (power of two, at least 2).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  col*psum_bw  SFP output word; lane k occupies bits [k*psum_bw +: psum_bw].
REQ-007 in_valid  input  1  in_data valid this cycle (driven from core ofifo_valid).
REQ-008 relu_en  input  1  when 1, negative lanes are zeroed on output.
REQ-009 out_data  output  psum_bw  one lane per transfer.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts the lane.
REQ-012 out_col  output  clog2(col)  lane index of out_data.
REQ-013 out_last  output  1  high with lane col-1.
REQ-014 full, empty  output  1 each  buffer status.
REQ-015 overflow  output  1  sticky flag: a word was dropped.

Function
REQ-016 SHALL push in_data into a circular buffer whenever in_valid=1 and the buffer is not full; write pointer wraps from depth-1 to 0.
REQ-017 SHALL drop in_data and set overflow when in_valid=1 and full=1, except when a pop occurs in the same cycle, in which case push and pop both succeed.
REQ-018 SHALL allow a simultaneous push and pop in any non-empty state, leaving the count unchanged.
REQ-019 SHALL assert full when count==depth and empty when count==0; both are registered and exact.
REQ-020 The serializer FSM SHALL have states IDLE and SHIFT.
REQ-021 IDLE -> SHIFT: buffer non-empty; the head word is popped into a col*psum_bw shift register and out_col=0.
REQ-022 In SHIFT, out_valid=1 and out_data=lane out_col; a transfer occurs when out_valid & out_ready.
REQ-023 On a transfer with out_col<col-1, out_col increments.
REQ-024 On a transfer with out_col==col-1, the FSM reloads the next word without a bubble if the buffer is non-empty; otherwise it returns to IDLE.
REQ-025 out_data, out_col and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Latency: a word pushed in cycle N presents lane 0 with out_valid=1 in cycle N+1 when the buffer was empty and the FSM was IDLE.
REQ-027 ReLU: a lane is treated as signed two's complement, and out_data=0 when relu_en=1 and the lane MSB=1; relu_en is sampled combinationally per lane.
REQ-028 Throughput: one lane per cycle under continuous out_ready; one input word per col cycles is sustained without overflow.

Reset
REQ-029 Asserting reset (low) SHALL immediately:
- clear pointers and count, giving empty=1 and full=0;
- set the FSM to IDLE with out_valid=0, out_col=0, out_last=0 and out_data=0;
- clear overflow.
REQ-030 Reset asserted mid-word SHALL discard the partial word and all buffered words; no lane is emitted after release until a new push.
REQ-031 overflow SHALL clear only on reset.

Structure
REQ-032 Shared package core_pkg SHALL hold the PSUM_BW and COL constants and the drain FSM state enumeration (IDLE, SHIFT).
REQ-033 The buffer SHALL be a sub-module psum_fifo providing push, pop, data, full, empty and count.
REQ-034 psum_drain instantiates psum_fifo plus the serializer FSM and the ReLU mux.

Verification
REQ-035 Single word: push lanes {0x0001..0x0008} with out_ready=1 -> 8 transfers, out_col 0..7, out_data 0x0001..0x0008, out_last on the 8th only, then IDLE with empty=1.
REQ-036 ReLU: push lane0=0xFFF0 and lane1=0x0010 with relu_en=1 -> out_data 0x0000 then 0x0010; with relu_en=0 -> 0xFFF0 then 0x0010.
REQ-037 Backpressure and overflow: hold out_ready=0, push 6 words -> 1 word in the shift register, 4 buffered, full=1, 1 dropped, overflow=1; release -> exactly 40 lanes, in order.
REQ-038 Back-to-back: push 3 words, then hold out_ready=1 -> 24 consecutive cycles with out_valid=1 and no bubble at word boundaries.
REQ-039 Full with simultaneous push and pop: full=1 and a transfer of lane 7 in the same cycle as in_valid=1 -> word accepted, overflow stays 0, full stays 1.
REQ-040 Reset mid-word: reset low at out_col=3 -> out_valid=0 and empty=1 asynchronously; no output after release until a new push.
